sram_like_mem_slave: RTL and testbench

Responder (slave) end of the sram-like data bus: accepts `data_req` transactions from a bus master such as the CPU data-bus bridge and services them against a single-port synchronous RAM. The RAM port may be shared, so access is gated by a grant. Requests are queued, and completions are returned strictly in order via `data_data_ok`. The block serves as the on-chip data-memory endpoint and as the bus-functional responder in the CPU benches.

---
 rtl/sram_like_pkg.sv | 30 +++
 rtl/sram_like_req_fifo.sv | 60 ++++++
 rtl/sram_like_mem_slave.sv | 120 ++++++++++++
 tb/tb_sram_like_mem_slave.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like bus responder.
// Contents: transfer-size encodings, the byte-enable derivation function and
// the packed request record stored in the request FIFO.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [3:0]  be;
    logic [29:0] addr;   // word address, byte address bits [31:2]
    logic [31:0] wdata;
  } req_t;

  // Size 2'b11 is treated like a word access.
  function automatic logic [3:0] size_to_be(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_like_req_fifo.sv
// Synchronous FIFO holding accepted requests until the RAM port grants them.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   push, push_data     : enqueue (ignored when full unless popping the same cycle)
//   pop                 : dequeue head (ignored when empty)
//   head                : current head entry (undefined while empty)
//   full, empty         : occupancy flags
module sram_like_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    used;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      used <= used + CW'(1);
      else if (do_pop && !do_push) used <= used - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (used == CW'(DEPTH));
  assign empty = (used == '0);

endmodule

// File: rtl/sram_like_mem_slave.sv
// Responder end of the sram-like data bus. Accepted requests are queued and
// issued in order to a shared single-port synchronous RAM when granted;
// completions are returned in acceptance order on data_data_ok.
// Ports:
//   clock, reset                          : clock, synchronous active-high reset
//   data_req/wr/size/addr/wdata           : master request and its fields
//   data_addr_ok                          : request accepted this cycle
//   data_data_ok, data_rdata              : in-order completion, read word
//   ram_en, ram_gnt                       : RAM access request / grant
//   ram_we, ram_addr, ram_wdata           : RAM write enables, word address, data
//   ram_rdata                             : RAM read data, RAM_LATENCY after grant
module sram_like_mem_slave
  import sram_like_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        ram_en,
  input  logic        ram_gnt,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned CW = $clog2(OUTSTANDING + 1);

  logic [CW-1:0]          count;
  logic                   accept;
  logic                   issue;
  logic                   fifo_full;
  logic                   fifo_empty;
  req_t                   push_req;
  req_t                   head_req;
  logic [RAM_LATENCY-1:0] valid_pipe;
  logic [RAM_LATENCY-1:0] read_pipe;

  // FIFO occupancy never exceeds count, so the full term never changes the
  // result; it only keeps the FIFO's own guard visible at the accept point.
  assign data_addr_ok = data_req && (count < CW'(OUTSTANDING)) && !fifo_full;
  assign accept       = data_req && data_addr_ok;

  always_comb begin
    push_req       = '0;
    push_req.wr    = data_wr;
    push_req.be    = size_to_be(data_size, data_addr[1:0]);
    push_req.addr  = data_addr[31:2];
    push_req.wdata = data_wdata;
  end

  sram_like_req_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH ($bits(req_t))
  ) u_req_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (push_req),
    .pop       (issue),
    .head      (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head fields are forced to zero while the queue is empty so the RAM side
  // shows clean values out of reset instead of stale storage.
  assign ram_en    = !fifo_empty;
  assign issue     = ram_en && ram_gnt;
  assign ram_addr  = ram_en ? {head_req.addr, 2'b00} : '0;
  assign ram_we    = (ram_en && head_req.wr) ? head_req.be : '0;
  assign ram_wdata = ram_en ? head_req.wdata : '0;

  if (RAM_LATENCY == 1) begin : g_pipe_single
    always_ff @(posedge clock) begin
      if (reset) begin
        valid_pipe <= '0;
        read_pipe  <= '0;
      end else begin
        valid_pipe <= issue;
        read_pipe  <= issue && !head_req.wr;
      end
    end
  end else begin : g_pipe_shift
    always_ff @(posedge clock) begin
      if (reset) begin
        valid_pipe <= '0;
        read_pipe  <= '0;
      end else begin
        valid_pipe <= {valid_pipe[RAM_LATENCY-2:0], issue};
        read_pipe  <= {read_pipe[RAM_LATENCY-2:0], issue && !head_req.wr};
      end
    end
  end

  assign data_data_ok = valid_pipe[RAM_LATENCY-1];
  assign data_rdata   = (data_data_ok && read_pipe[RAM_LATENCY-1]) ? ram_rdata : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({accept, data_data_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Directed self-checking bench for sram_like_mem_slave (OUTSTANDING=2,
// RAM_LATENCY=1) with a small byte-writable RAM model behind the grant.
module tb_sram_like_mem_slave;

  logic        clock;
  logic        reset;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        ram_en;
  logic        ram_gnt;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  sram_like_mem_slave #(
    .OUTSTANDING (2),
    .RAM_LATENCY (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .ram_en       (ram_en),
    .ram_gnt      (ram_gnt),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: word array, preloaded on reset, one-cycle read latency.
  logic [31:0] ram [0:255];
  always @(posedge clock) begin
    if (reset) begin
      ram[8'h00] <= 32'hCAFEF00D;
      ram[8'h04] <= 32'hDEADBEEF;
      ram[8'h08] <= 32'h11223344;
    end else if (ram_en && ram_gnt) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= ram[ram_addr[9:2]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic req, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    data_req   = req;
    data_wr    = wr;
    data_size  = size;
    data_addr  = addr;
    data_wdata = wdata;
  endtask

  // Single transaction with the grant held high: accept, issue, complete.
  task automatic do_txn(input string tag, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] exp_we, input logic [31:0] exp_addr,
                        input logic [31:0] exp_rdata);
    ram_gnt = 1'b1;
    drive(1'b1, wr, size, addr, wdata);
    @(negedge clock);
    check({tag, ".addr_ok"}, data_addr_ok, 1);
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clock);
    check({tag, ".ram_en"}, ram_en, 1);
    check({tag, ".ram_addr"}, ram_addr, exp_addr);
    check({tag, ".ram_we"}, ram_we, exp_we);
    if (wr) check({tag, ".ram_wdata"}, ram_wdata, wdata);
    check({tag, ".early_data_ok"}, data_data_ok, 0);
    next_cycle();
    @(negedge clock);
    check({tag, ".data_ok"}, data_data_ok, 1);
    check({tag, ".rdata"}, data_rdata, exp_rdata);
    check({tag, ".ram_en_idle"}, ram_en, 0);
    next_cycle();
    @(negedge clock);
    check({tag, ".data_ok_drop"}, data_data_ok, 0);
    next_cycle();
  endtask

  initial begin
    reset   = 1'b1;
    ram_gnt = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    next_cycle();
    @(negedge clock);
    check("rst.addr_ok", data_addr_ok, 0);
    check("rst.data_ok", data_data_ok, 0);
    check("rst.rdata", data_rdata, 0);
    check("rst.ram_en", ram_en, 0);
    check("rst.ram_we", ram_we, 0);
    check("rst.ram_addr", ram_addr, 0);
    check("rst.ram_wdata", ram_wdata, 0);
    next_cycle();
    reset = 1'b0;

    // Basic read, then byte/half/word writes with read-back.
    do_txn("rd10", 1'b0, 2'b10, 32'h10, 32'h0, 4'b0000, 32'h10, 32'hDEADBEEF);
    do_txn("wb13", 1'b1, 2'b00, 32'h13, 32'hAB000000, 4'b1000, 32'h10, 32'h0);
    do_txn("rd10b", 1'b0, 2'b10, 32'h10, 32'h0, 4'b0000, 32'h10, 32'hABADBEEF);
    do_txn("wb11", 1'b1, 2'b00, 32'h11, 32'h0000EE00, 4'b0010, 32'h10, 32'h0);
    do_txn("rd10c", 1'b0, 2'b10, 32'h12, 32'h0, 4'b0000, 32'h10, 32'hABADEEEF);
    do_txn("wh22", 1'b1, 2'b01, 32'h22, 32'h55660000, 4'b1100, 32'h20, 32'h0);
    do_txn("wh20", 1'b1, 2'b01, 32'h21, 32'h00007788, 4'b0011, 32'h20, 32'h0);
    do_txn("rd20", 1'b0, 2'b10, 32'h20, 32'h0, 4'b0000, 32'h20, 32'h55667788);
    do_txn("ws11", 1'b1, 2'b11, 32'h43, 32'h01020304, 4'b1111, 32'h40, 32'h0);

    // Back-pressure: two reads fill the queue while ungranted, third waits.
    ram_gnt = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    @(negedge clock);
    check("bp.acc1", data_addr_ok, 1);
    next_cycle();
    drive(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
    @(negedge clock);
    check("bp.acc2", data_addr_ok, 1);
    check("bp.head1", ram_addr, 32'h10);
    next_cycle();
    drive(1'b1, 1'b0, 2'b10, 32'h00, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp.full_hold", data_addr_ok, 0);
      check("bp.no_data_ok", data_data_ok, 0);
      next_cycle();
    end
    ram_gnt = 1'b1;
    @(negedge clock);
    check("bp.gnt_addr_ok", data_addr_ok, 0);
    check("bp.gnt_head", ram_addr, 32'h10);
    next_cycle();
    @(negedge clock);
    check("bp.c1_ok", data_data_ok, 1);
    check("bp.c1_rdata", data_rdata, 32'hABADEEEF);
    check("bp.full_on_cpl", data_addr_ok, 0);
    check("bp.head2", ram_addr, 32'h20);
    next_cycle();
    @(negedge clock);
    check("bp.c2_ok", data_data_ok, 1);
    check("bp.c2_rdata", data_rdata, 32'h55667788);
    check("bp.acc3", data_addr_ok, 1);
    check("bp.empty", ram_en, 0);
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clock);
    check("bp.gap", data_data_ok, 0);
    check("bp.head3", ram_addr, 32'h00);
    check("bp.head3_en", ram_en, 1);
    next_cycle();
    @(negedge clock);
    check("bp.c3_ok", data_data_ok, 1);
    check("bp.c3_rdata", data_rdata, 32'hCAFEF00D);
    next_cycle();

    // Grant stall: write then read of 0x30 with the grant toggling.
    ram_gnt = 1'b0;
    drive(1'b1, 1'b1, 2'b10, 32'h30, 32'h12345678);
    @(negedge clock);
    check("gs.acc_w", data_addr_ok, 1);
    next_cycle();
    ram_gnt = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 32'h30, 32'h0);
    @(negedge clock);
    check("gs.acc_r", data_addr_ok, 1);
    check("gs.w_addr", ram_addr, 32'h30);
    check("gs.w_we", ram_we, 4'b1111);
    check("gs.w_wdata", ram_wdata, 32'h12345678);
    next_cycle();
    ram_gnt = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clock);
    check("gs.w_ok", data_data_ok, 1);
    check("gs.w_rdata", data_rdata, 0);
    check("gs.r_addr", ram_addr, 32'h30);
    check("gs.r_we", ram_we, 4'b0000);
    next_cycle();
    ram_gnt = 1'b1;
    @(negedge clock);
    check("gs.stall_no_ok", data_data_ok, 0);
    check("gs.r_en_stable", ram_en, 1);
    check("gs.r_addr_stable", ram_addr, 32'h30);
    check("gs.r_we_stable", ram_we, 4'b0000);
    next_cycle();
    ram_gnt = 1'b0;
    @(negedge clock);
    check("gs.r_ok", data_data_ok, 1);
    check("gs.r_rdata", data_rdata, 32'h12345678);
    check("gs.idle", ram_en, 0);
    next_cycle();
    @(negedge clock);
    check("gs.no_dup", data_data_ok, 0);
    next_cycle();

    // Reset with two reads in flight: nothing completes, new read accepted.
    ram_gnt = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    @(negedge clock);
    check("rs.acc1", data_addr_ok, 1);
    next_cycle();
    drive(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
    @(negedge clock);
    check("rs.acc2", data_addr_ok, 1);
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    ram_gnt = 1'b1;
    reset   = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 32'h00, 32'h0);
    @(negedge clock);
    check("rs.post_addr_ok", data_addr_ok, 1);
    check("rs.post_data_ok", data_data_ok, 0);
    check("rs.post_ram_en", ram_en, 0);
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clock);
    check("rs.no_stale_ok", data_data_ok, 0);
    check("rs.new_head", ram_addr, 32'h00);
    check("rs.new_en", ram_en, 1);
    next_cycle();
    @(negedge clock);
    check("rs.new_ok", data_data_ok, 1);
    check("rs.new_rdata", data_rdata, 32'hCAFEF00D);
    next_cycle();
    @(negedge clock);
    check("rs.quiet", data_data_ok, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
